instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Consumer side of the program-counter register in the multicycle CPU. On a fetch command from the control unit it samples the current PC, issues a word read to instruction memory over a valid/ready request channel, and captures the returned word into the instruction register (IR). It reports completion and alignment errors back to the control unit, which raises PC WE only after fetch_done.

Parameters:
ADDR_W, 32, width of PC / memory address
DATA_W, 32, instruction word width
TIMEOUT_CYC, 15, cycles in WAIT before timeout abort (used only with the optional feature)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  asynchronous reset, active-high
fetch_start  in  1  one-cycle command from control unit; ignored unless idle
pc_in  in  ADDR_W  current PC value, sampled on the accepted fetch_start
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  request address, byte address, word aligned
mem_rsp_valid  in  1  read data valid, one-cycle pulse
mem_rsp_data  in  DATA_W  read data
ir_out  out  DATA_W  instruction register contents
fetch_done  out  1  one-cycle pulse; IR updated
busy  out  1  high in any state except IDLE
fetch_err  out  1  sticky error flag; cleared by next accepted fetch_start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; mem_req_valid=0; mem_addr=0; ir_out=0; fetch_done=0; busy=0; fetch_err=0. Applies mid-transaction; an in-flight memory response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on fetch_start=1, latch pc_in into addr_q and clear fetch_err.
  - If pc_in[1:0]!=0: set fetch_err=1, go to DONE. No memory request is issued and IR is unchanged.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, mem_addr=addr_q. Both are held stable until mem_req_ready=1 is sampled. The handshake completes in the cycle where valid and ready are both high; then go to WAIT.
- WAIT: mem_req_valid=0. On mem_rsp_valid=1, ir_out<=mem_rsp_data, then go to DONE. A response in the same cycle as the request handshake is not accepted; minimum latency is one cycle after acceptance.
- DONE: fetch_done=1 for exactly one cycle, then IDLE.
- Latency, fetch_start to fetch_done, with ready=1 and response one cycle after acceptance: 4 cycles (IDLE->REQ->WAIT->DONE, pulse in the 4th cycle).
- fetch_start while busy=1: ignored, no queuing.
- Response while not in WAIT: ignored.
- ir_out holds its value between fetches, and on error or timeout.
- Address arithmetic: none. The address is passed unmodified; no wrap handling is needed.

Optional Feature:
Macro: FETCH_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle without mem_rsp_valid.
  - When the count reaches TIMEOUT_CYC: set fetch_err=1, go to DONE, IR unchanged.
  - A response arriving in the same cycle as the terminal count wins: IR is loaded and no error is raised.
- Not defined: WAIT lasts indefinitely; there is no counter logic and TIMEOUT_CYC is unused.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3)
  - ADDR_W/DATA_W defaults
  - alignment mask constant 2'b11
- One natural sub-module: fetch_timeout_ctr, the WAIT-cycle counter with clear/enable/terminal-count output, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Basic fetch: pc_in=0x00000040, fetch_start pulse, ready=1, rsp one cycle after accept with data 0x8C010004 -> mem_addr=0x40, ir_out=0x8C010004, fetch_done in 4th cycle, fetch_err=0.
- Backpressure: ready low for 3 cycles -> mem_req_valid and mem_addr=0x44 stable throughout, one request accepted, fetch_done after response.
- Misaligned: pc_in=0x00000042 -> no mem_req_valid, fetch_err=1, fetch_done pulse, ir_out unchanged. Next aligned fetch clears fetch_err.
- Reset mid-WAIT: assert RST in WAIT, then deliver rsp 0xDEADBEEF -> ir_out=0, state IDLE, no fetch_done.
- Ignored start: second fetch_start while busy with pc_in=0x100 -> only the original address is fetched, exactly one fetch_done.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=15: no response -> fetch_err=1 and fetch_done 15 cycles after entering WAIT. Response on the terminal cycle -> IR loaded, fetch_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_TIMEOUT_EN (see instr_fetch_unit).
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Low PC bits that must be zero for a word-aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// WAIT-cycle counter for the fetch unit. Cleared on WAIT entry, counts each
// WAIT cycle without a response; tc_o flags the cycle whose increment would
// bring the count to TIMEOUT_CYC. Only instantiated under FETCH_TIMEOUT_EN.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the PC on fetch_start, issues one word read
// over a valid/ready channel, loads the returned word into IR and pulses
// fetch_done. Misaligned PCs raise the sticky fetch_err without a request.
// Optional macro FETCH_TIMEOUT_EN aborts WAIT after TIMEOUT_CYC cycles.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] ir_out,
  output logic              fetch_done,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              err_q, err_d;
  logic              tmo_tc;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk   (CLK),
    .rst   (RST),
    .clr_i ((state_q == REQ) && mem_req_ready),
    .en_i  ((state_q == WAIT) && !mem_rsp_valid),
    .tc_o  (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  // Next-state and datapath update logic for the fetch sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          addr_d = pc_in;
          if (is_misaligned(pc_in[1:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response on the terminal-count cycle takes priority over timeout.
        if (mem_rsp_valid) begin
          ir_d    = mem_rsp_data;
          state_d = DONE;
        end else if (tmo_tc) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign ir_out        = ir_q;
  assign fetch_done    = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign fetch_err     = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Timeout cases run when
// FETCH_TIMEOUT_EN is defined; otherwise an unbounded WAIT is exercised.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] ir;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic [31:0] pc_in = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [31:0] ir_out;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int          nvec = 0;
  int          nmis = 0;
  logic [31:0] exp_ir = '0;
  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];

  instr_fetch_unit #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (15)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .fetch_start   (fetch_start),
    .pc_in         (pc_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ir_out        (ir_out),
    .fetch_done    (fetch_done),
    .busy          (busy),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic vchk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: request handshakes and completion pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0) vchk("unexpected_req", 64'(mem_req_valid), 64'(0));
        else vchk("req_accept_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (fetch_done) begin
        if (exp_q.size() == 0) begin
          vchk("spurious_done", 64'(fetch_done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          vchk("ir_out", 64'(ir_out), 64'(e.ir));
          vchk("fetch_err", 64'(fetch_err), 64'(e.err));
        end
      end
    end
  end

  // Aligned fetch: ready held low for ready_lo cycles, response rsp_gap
  // cycles after the earliest legal cycle; stray starts injected while busy.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                           input int unsigned ready_lo, input int unsigned rsp_gap,
                           input logic stray);
    fetch_start = 1'b1;
    pc_in       = pc;
    tick(1);
    fetch_start = 1'b0;
    pc_in       = '0;
    exp_addr_q.push_back(pc);
    exp_ir = data;
    exp_q.push_back('{ir: data, err: 1'b0});
    vchk("busy_req", 64'(busy), 64'(1));
    vchk("err_clr", 64'(fetch_err), 64'(0));
    for (int i = 0; i < int'(ready_lo); i++) begin
      vchk("req_valid_hold", 64'(mem_req_valid), 64'(1));
      vchk("req_addr_hold", 64'(mem_addr), 64'(pc));
      if (stray && i == 0) begin
        fetch_start = 1'b1;
        pc_in       = 32'h100;
      end
      tick(1);
      fetch_start = 1'b0;
      pc_in       = '0;
    end
    mem_req_ready = 1'b1;
    vchk("req_valid", 64'(mem_req_valid), 64'(1));
    vchk("req_addr", 64'(mem_addr), 64'(pc));
    tick(1);
    mem_req_ready = 1'b0;
    vchk("wait_valid_low", 64'(mem_req_valid), 64'(0));
    for (int i = 0; i < int'(rsp_gap); i++) begin
      if (stray && i == 0) begin
        fetch_start = 1'b1;
        pc_in       = 32'h100;
      end
      mem_rsp_data = $urandom;
      tick(1);
      fetch_start = 1'b0;
      pc_in       = '0;
      vchk("wait_busy", 64'(busy), 64'(1));
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick(1);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    vchk("done_pulse", 64'(fetch_done), 64'(1));
    tick(1);
    vchk("done_one_cycle", 64'(fetch_done), 64'(0));
    vchk("back_idle", 64'(busy), 64'(0));
  endtask

  task automatic run_misaligned(input logic [31:0] pc);
    mem_req_ready = 1'b1;
    fetch_start   = 1'b1;
    pc_in         = pc;
    tick(1);
    fetch_start = 1'b0;
    pc_in       = '0;
    exp_q.push_back('{ir: exp_ir, err: 1'b1});
    vchk("misalign_done", 64'(fetch_done), 64'(1));
    vchk("misalign_err", 64'(fetch_err), 64'(1));
    vchk("misalign_no_req", 64'(mem_req_valid), 64'(0));
    tick(1);
    mem_req_ready = 1'b0;
    vchk("misalign_idle", 64'(busy), 64'(0));
    vchk("err_sticky", 64'(fetch_err), 64'(1));
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tick(2);
    vchk("rst_valid", 64'(mem_req_valid), 64'(0));
    vchk("rst_addr", 64'(mem_addr), 64'(0));
    vchk("rst_ir", 64'(ir_out), 64'(0));
    vchk("rst_done", 64'(fetch_done), 64'(0));
    vchk("rst_busy", 64'(busy), 64'(0));
    vchk("rst_err", 64'(fetch_err), 64'(0));
    rst = 1'b0;
    tick(1);

    run_fetch(32'h0000_0040, 32'h8C01_0004, 0, 0, 1'b0);
    run_fetch(32'h0000_0044, 32'h1234_5678, 3, 0, 1'b1);
    run_fetch(32'h0000_0048, 32'hCAFE_F00D, 1, 2, 1'b1);

    run_misaligned(32'h0000_0042);
    run_misaligned(32'h0000_0101);
    run_misaligned(32'hFFFF_FFFF);
    run_fetch(32'h0000_004C, 32'h0BAD_C0DE, 0, 0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    fetch_start = 1'b1;
    pc_in       = 32'h0000_0200;
    tick(1);
    fetch_start = 1'b0;
    exp_addr_q.push_back(32'h0000_0200);
    exp_q.push_back('{ir: exp_ir, err: 1'b1});
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    n = 0;
    while (!fetch_done && n < 40) begin
      tick(1);
      n++;
    end
    vchk("tmo_latency", 64'(n), 64'(15));
    vchk("tmo_err", 64'(fetch_err), 64'(1));
    tick(1);

    fetch_start = 1'b1;
    pc_in       = 32'h0000_0204;
    tick(1);
    fetch_start = 1'b0;
    exp_addr_q.push_back(32'h0000_0204);
    exp_ir = 32'h600D_DA7A;
    exp_q.push_back('{ir: 32'h600D_DA7A, err: 1'b0});
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    tick(14);
    vchk("tc_still_wait", 64'(busy && !fetch_done), 64'(1));
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h600D_DA7A;
    tick(1);
    mem_rsp_valid = 1'b0;
    vchk("tc_done", 64'(fetch_done), 64'(1));
    vchk("tc_no_err", 64'(fetch_err), 64'(0));
    tick(1);
`else
    run_fetch(32'h0000_0080, 32'hA5A5_5A5A, 0, 25, 1'b0);
`endif

    // Reset while waiting for the memory response.
    fetch_start = 1'b1;
    pc_in       = 32'h0000_0300;
    tick(1);
    fetch_start = 1'b0;
    exp_addr_q.push_back(32'h0000_0300);
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    tick(1);
    rst = 1'b1;
    #2;
    exp_q.delete();
    exp_addr_q.delete();
    exp_ir = '0;
    vchk("midrst_ir", 64'(ir_out), 64'(0));
    vchk("midrst_busy", 64'(busy), 64'(0));
    vchk("midrst_addr", 64'(mem_addr), 64'(0));
    vchk("midrst_err", 64'(fetch_err), 64'(0));
    tick(1);
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick(1);
    mem_rsp_valid = 1'b0;
    vchk("late_rsp_ir", 64'(ir_out), 64'(0));
    vchk("late_rsp_done", 64'(fetch_done), 64'(0));
    vchk("late_rsp_busy", 64'(busy), 64'(0));
    tick(1);

    run_fetch(32'h0000_0400, 32'h0102_0304, 0, 0, 1'b0);

    vchk("sb_done_left", 64'(exp_q.size()), 64'(0));
    vchk("sb_req_left", 64'(exp_addr_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
